// File: rtl/int8_acc_pkg.sv
// Shared widths and FSM state encoding for the int8 partial-sum accumulate/requant path.
package int8_acc_pkg;

  localparam int PSUM_W  = 24;
  localparam int ACC_W   = 32;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 10;
  localparam int OUT_W   = 8;
  localparam int PROD_W  = ACC_W + SCALE_W + 1;

  localparam logic signed [OUT_W-1:0] INT8_MIN = -8'sd128;
  localparam logic signed [OUT_W-1:0] INT8_MAX = 8'sd127;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    MULT  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/int8_round_sat.sv
// Combinational round-half-up right shift of a scaled product, clamped to int8.
// Optional INT8_REQUANT_RELU_EN: negative results forced to 0 after the clamp.
module int8_round_sat
  import int8_acc_pkg::*;
(
  input  logic signed [PROD_W-1:0]  prod,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      clamped
);

  // One guard bit so adding the rounding term can never wrap.
  localparam int SUM_W = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(INT8_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(INT8_MIN);

  logic signed [SUM_W-1:0] rnd;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    rnd      = '0;
    sum      = '0;
    shifted  = '0;
    out_data = '0;
    clamped  = 1'b0;
    if (shift != '0) begin
      rnd = SUM_W'(1) << (shift - SHIFT_W'(1));
    end
    sum     = $signed({prod[PROD_W-1], prod}) + rnd;
    shifted = sum >>> shift;
    if (shifted > SAT_HI) begin
      out_data = INT8_MAX;
      clamped  = 1'b1;
    end else if (shifted < SAT_LO) begin
      out_data = INT8_MIN;
      clamped  = 1'b1;
    end else begin
      out_data = shifted[OUT_W-1:0];
    end
`ifdef INT8_REQUANT_RELU_EN
    if (out_data[OUT_W-1]) begin
      out_data = '0;
    end
`endif
  end

endmodule

// File: rtl/int8_psum_requant.sv
// Accumulates signed partial sums for one output element, then requantizes to int8.
// Build option INT8_REQUANT_RELU_EN (in int8_round_sat) clamps negative results to 0.
module int8_psum_requant
  import int8_acc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic        [SCALE_W-1:0] cfg_scale,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic signed [PSUM_W-1:0]  psum_data,
  input  logic                      psum_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic        [CNT_W-1:0]   out_beats
);

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
  endfunction

  state_t state, state_nxt;

  logic signed [ACC_W-1:0]   acc_p0;
  logic        [CNT_W-1:0]   beats_p0;
  logic                      ovf_p0;
  logic        [SCALE_W-1:0] scale_p0;
  logic        [SHIFT_W-1:0] shift_p0;
  logic signed [PROD_W-1:0]  prod_p1;

  logic signed [ACC_W:0]     acc_sum;
  logic                      acc_clamp;
  logic                      psum_fire;
  logic signed [OUT_W-1:0]   rs_data;
  logic                      rs_clamped;

  assign psum_ready = (state == ACCUM);
  assign psum_fire  = psum_valid & psum_ready;
  assign acc_sum    = $signed({acc_p0[ACC_W-1], acc_p0})
                    + $signed({{(ACC_W+1-PSUM_W){psum_data[PSUM_W-1]}}, psum_data});
  assign acc_clamp  = (acc_sum[ACC_W] != acc_sum[ACC_W-1]);

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (psum_fire && psum_last) state_nxt = MULT;
      MULT:    state_nxt = ROUND;
      ROUND:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // p0: accumulate partial sums and latch requant config on the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0   <= '0;
      beats_p0 <= '0;
      ovf_p0   <= 1'b0;
    end else if (state == ACCUM && psum_fire) begin
      acc_p0   <= sat_acc(acc_sum);
      ovf_p0   <= ovf_p0 | acc_clamp;
      beats_p0 <= (beats_p0 == '1) ? beats_p0 : beats_p0 + CNT_W'(1);
    end else if (state == HOLD && out_ready) begin
      acc_p0   <= '0;
      beats_p0 <= '0;
      ovf_p0   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (psum_fire && psum_last) begin
      scale_p0 <= cfg_scale;
      shift_p0 <= cfg_shift;
    end
  end

  // p1: scale the accumulated total
  always_ff @(posedge clk) begin
    if (state == MULT) begin
      prod_p1 <= $signed({{(PROD_W-ACC_W){acc_p0[ACC_W-1]}}, acc_p0})
               * $signed({{(PROD_W-SCALE_W){1'b0}}, scale_p0});
    end
  end

  int8_round_sat u_round_sat (
    .prod     (prod_p1),
    .shift    (shift_p0),
    .out_data (rs_data),
    .clamped  (rs_clamped)
  );

  // p2: round/saturate result registered onto the output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_beats <= '0;
    end else if (state == ROUND) begin
      out_valid <= 1'b1;
      out_data  <= rs_data;
      out_sat   <= ovf_p0 | rs_clamped;
      out_beats <= beats_p0;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int8_psum_requant.sv
// Directed scoreboard bench for int8_psum_requant; honours INT8_REQUANT_RELU_EN if defined.
module tb_int8_psum_requant;
  import int8_acc_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic        [SCALE_W-1:0] cfg_scale;
  logic        [SHIFT_W-1:0] cfg_shift;
  logic                      psum_valid;
  logic                      psum_ready;
  logic signed [PSUM_W-1:0]  psum_data;
  logic                      psum_last;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_sat;
  logic        [CNT_W-1:0]   out_beats;

  int8_psum_requant dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_scale  (cfg_scale),
    .cfg_shift  (cfg_shift),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .psum_last  (psum_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_beats  (out_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint sat;
    longint beats;
  } exp_t;

  exp_t   sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint m_acc   = 0;
  longint m_ovf   = 0;
  longint m_beats = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc   = 0;
    m_ovf   = 0;
    m_beats = 0;
  endtask

  // Reference: saturating accumulate, then scale, round half up, clamp, optional ReLU.
  task automatic model_beat(input longint d, input bit last);
    exp_t   e;
    longint prod;
    longint r;
    m_acc = m_acc + d;
    if (m_acc > 64'sd2147483647) begin
      m_acc = 64'sd2147483647;
      m_ovf = 1;
    end else if (m_acc < -64'sd2147483648) begin
      m_acc = -64'sd2147483648;
      m_ovf = 1;
    end
    if (m_beats < 1023) m_beats++;
    if (last) begin
      prod = m_acc * longint'(cfg_scale);
      if (cfg_shift != 0) prod = prod + (64'sd1 <<< (cfg_shift - 1));
      r = prod >>> cfg_shift;
      e.sat = m_ovf;
      if (r > 127) begin
        r = 127;
        e.sat = 1;
      end else if (r < -128) begin
        r = -128;
        e.sat = 1;
      end
`ifdef INT8_REQUANT_RELU_EN
      if (r < 0) r = 0;
`endif
      e.data  = r;
      e.beats = m_beats;
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic send_beat(input longint d, input bit last);
    int guard = 0;
    psum_valid = 1'b1;
    psum_data  = d[PSUM_W-1:0];
    psum_last  = last;
    while (!psum_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!psum_ready) check("psum_ready_timeout", psum_ready, 1);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    model_beat(d, last);
  endtask

  task automatic get_result(input string tag, input int stall);
    int   waited = 0;
    exp_t e;
    while (!out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_valid"}, out_valid, 1);
    if (!out_valid) return;
    check({tag, "_latency"}, waited, 2);
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, out_valid, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_data"}, out_data, e.data);
    check({tag, "_sat"}, out_sat, e.sat);
    check({tag, "_beats"}, out_beats, e.beats);
    check({tag, "_psum_ready_busy"}, psum_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_data"}, out_data, e.data);
      check({tag, "_stall_ready"}, psum_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, psum_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    cfg_scale  = '0;
    cfg_shift  = '0;
    psum_valid = 1'b0;
    psum_data  = '0;
    psum_last  = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psum_ready", psum_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_beats", out_beats, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 100+200-50 = 250 saturates int8
    cfg_scale = 16'd1; cfg_shift = 5'd0;
    send_beat(100, 0);
    send_beat(200, 0);
    send_beat(-50, 1);
    get_result("t1", 0);

    // (750+4)>>>3 = 94; config changed after the last beat must not matter
    cfg_scale = 16'd3; cfg_shift = 5'd3;
    send_beat(250, 1);
    cfg_scale = 16'hFFFF; cfg_shift = 5'd0;
    get_result("t2", 0);

    // -20 with shift 3 rounds to -2 (0 under ReLU)
    cfg_scale = 16'd1; cfg_shift = 5'd3;
    send_beat(-20, 1);
    get_result("t3", 0);

    // stalled consumer, then a fresh 2-beat element
    cfg_scale = 16'd1; cfg_shift = 5'd0;
    send_beat(33, 1);
    get_result("t4_stall", 5);
    send_beat(5, 0);
    send_beat(7, 1);
    get_result("t4_fresh", 0);

    // accumulator overflow clamps at 2^31-1
    cfg_scale = 16'd1; cfg_shift = 5'd0;
    for (int i = 0; i < 300; i++) send_beat(64'sh7FFFFF, i == 299);
    get_result("t5_ovf", 0);

    // negative int8 clamp
    cfg_scale = 16'd1; cfg_shift = 5'd0;
    send_beat(-1000, 1);
    get_result("neg_clamp", 0);

    // scale 0 yields 0
    cfg_scale = 16'd0; cfg_shift = 5'd4;
    send_beat(12345, 1);
    get_result("scale0", 0);

    // reset mid-element discards partial state
    cfg_scale = 16'd1; cfg_shift = 5'd0;
    send_beat(40, 0);
    send_beat(41, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("t6_ready_after_rst", psum_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t6_no_valid", out_valid, 0);
    end
    cfg_scale = 16'd2; cfg_shift = 5'd1;
    send_beat(10, 1);
    get_result("t6_fresh", 0);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
